// File: rtl/aes_enc_core.sv
`default_nettype none
// ============================================================================
// aes_enc_core : iterative AES-128 encryption core, one cipher round per clock
// Revision     : 1.0
// ============================================================================
module aes_enc_core #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic         ready,
  output logic [3:0]   rk_sel,
  input  logic [127:0] rk,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ciphertext
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ROUND = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [7:0] c_POLY       = 8'h1b;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
    $error("aes_enc_core: only NUM_ROUNDS = 10 (AES-128) is supported");
  end

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return c_SBOX[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? c_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [1:0]   r_state;
  logic [3:0]   r_round;
  logic [127:0] r_data;

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_round_out;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign w_sb[127-8*i -: 8] = sbox(r_data[127-8*i -: 8]);
  end

  // Row r of each column is taken from column (c + r) mod 4.
  assign w_sr = {w_sb[127:120], w_sb[87:80],   w_sb[47:40],   w_sb[7:0],
                 w_sb[95:88],   w_sb[55:48],   w_sb[15:8],    w_sb[103:96],
                 w_sb[63:56],   w_sb[23:16],   w_sb[111:104], w_sb[71:64],
                 w_sb[31:24],   w_sb[119:112], w_sb[79:72],   w_sb[39:32]};

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
  end

  assign w_round_out = ((r_round == c_LAST_ROUND) ? w_sr : w_mc) ^ rk;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= c_IDLE;
      r_round <= 4'd0;
      r_data  <= 128'h0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_data  <= plaintext ^ rk;
            r_round <= 4'd1;
            r_state <= c_ROUND;
          end
        end
        c_ROUND: begin
          r_data <= w_round_out;
          if (r_round == c_LAST_ROUND) begin
            r_state <= c_DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        c_DONE: begin
          if (ct_ready) begin
            r_state <= c_IDLE;
            r_round <= 4'd0;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_round <= 4'd0;
        end
      endcase
    end
  end

  assign ready      = (r_state == c_IDLE);
  assign ct_valid   = (r_state == c_DONE);
  assign rk_sel     = (r_state == c_IDLE) ? 4'd0 : r_round;
  // Gate the state register so intermediate round values never reach the port.
  assign ciphertext = (r_state == c_DONE) ? r_data : 128'h0;

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_core.sv
`default_nettype none
// ============================================================================
// tb_aes_enc_core : directed and reference-model checks for aes_enc_core
// Revision        : 1.0
// ============================================================================
module tb_aes_enc_core;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic         ct_ready = 1'b0;
  logic [127:0] plaintext = 128'h0;
  logic [127:0] rk;
  logic [127:0] ciphertext;
  logic         ready;
  logic         ct_valid;
  logic [3:0]   rk_sel;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]   sb [256];
  logic [127:0] rks [11];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] c_B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rk = 128'h0;
    if (rk_sel <= 4'd10) rk = rks[rk_sel];
  end

  aes_enc_core #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .plaintext  (plaintext),
    .ready      (ready),
    .rk_sel     (rk_sel),
    .rk         (rk),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .ciphertext (ciphertext)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          s[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic wait_ready();
    for (int n = 0; n < 40 && !ready; n++) @(negedge clk);
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  // One block from accept to handoff; optional rk_sel tracking, stray start
  // pulses, and a 20-cycle backpressure hold with input churn.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp,
                           input string nm, input bit chk_rk, input bit pulses,
                           input bit bp);
    wait_ready();
    if (chk_rk) chk({nm, "_rksel_0"}, rk_sel, 0);
    start = 1'b1;
    plaintext = pt;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = pulses && (k == 3 || k == 7);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      if (k == 1) chk({nm, "_ready_drop"}, ready, 0);
      if (chk_rk && k <= 10) chk($sformatf("%s_rksel_%0d", nm, k), rk_sel, k);
      if (k == 10) chk({nm, "_valid_early"}, ct_valid, 0);
    end
    start = 1'b0;
    chk({nm, "_valid"}, ct_valid, 1);
    chk({nm, "_ct"}, ciphertext, exp);
    if (bp) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        if (i == 10) set_key({$urandom, $urandom, $urandom, $urandom});
        chk($sformatf("%s_hold_%0d", nm, i), {ct_valid, ready, ciphertext[125:0]},
            {1'b1, 1'b0, exp[125:0]});
      end
      ct_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ct_ready = 1'b0;
      chk({nm, "_release"}, {ready, ct_valid}, 2'b10);
      @(negedge clk);
      chk({nm, "_no_handoff_accept"}, ready, 1);
    end else begin
      ct_ready = 1'b1;
      @(negedge clk);
      ct_ready = 1'b0;
      chk({nm, "_to_idle"}, {ready, ct_valid}, 2'b10);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt;
    logic [127:0] exp;
    int last;
    int n;

    vecs[0] = '{pt: c_B_PT, key: c_B_KEY, ct: c_B_CT};
    vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{pt: 128'h0, key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    build_sbox();
    set_key(c_B_KEY);

    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_ciphertext", ciphertext, 0);
    chk("rst_rk_sel", rk_sel, 0);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      set_key(vecs[i].key);
      run_block(vecs[i].pt, vecs[i].ct, $sformatf("vec%0d", i), i == 0, 1'b0, 1'b0);
    end

    set_key(c_B_KEY);
    run_block(c_B_PT, c_B_CT, "pulse", 1'b1, 1'b1, 1'b0);
    run_block(c_B_PT, c_B_CT, "bp", 1'b0, 1'b0, 1'b1);

    // Abort at round 5 with an asynchronous reset, then rerun.
    set_key(c_B_KEY);
    wait_ready();
    start = 1'b1;
    plaintext = c_B_PT;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rksel_round5", rk_sel, 5);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_ct_valid", ct_valid, 0);
    chk("mid_rst_ciphertext", ciphertext, 0);
    chk("mid_rst_rk_sel", rk_sel, 0);
    @(negedge clk);
    n_rst = 1'b1;
    run_block(c_B_PT, c_B_CT, "after_rst", 1'b0, 1'b0, 1'b0);

    set_key({$urandom, $urandom, $urandom, $urandom});
    ct_ready = 1'b1;
    last = 0;
    for (int b = 0; b < 100; b++) begin
      wait_ready();
      if (b > 0) chk($sformatf("b2b_period_%0d", b), cyc - last, 12);
      last = cyc;
      pt = {$urandom, $urandom, $urandom, $urandom};
      exp = aes_ref(pt);
      start = 1'b1;
      plaintext = pt;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!ct_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("b2b_latency_%0d", b), n, 11);
      chk($sformatf("b2b_ct_%0d", b), ciphertext, exp);
    end
    ct_ready = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
